// File: rtl/click_bcd_display_pkg.sv
// Shared constants and helpers for the click-driven BCD counter and its 7-segment scanner.
// Segment patterns are active-high, bit0 = a ... bit6 = g.
package click_bcd_display_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    function automatic int unsigned bcd_width(input int unsigned digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/click_bcd_display_if.sv
// Click pulses in, counter and display pins out; master is the key stage, slave the display block.
interface click_bcd_display_if #(
    parameter int unsigned DIGITS = 4
) ();

    logic                                                  inc_i;
    logic                                                  dec_i;
    logic                                                  clr_i;
    logic [click_bcd_display_pkg::bcd_width(DIGITS)-1:0]   count_o;
    logic                                                  wrap_o;
    logic [7:0]                                            seg_o;
    logic [DIGITS-1:0]                                     dig_sel_o;

    modport master (
        output inc_i, dec_i, clr_i,
        input  count_o, wrap_o, seg_o, dig_sel_o
    );

    modport slave (
        input  inc_i, dec_i, clr_i,
        output count_o, wrap_o, seg_o, dig_sel_o
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern; non-BCD codes show a dash.
module seg7_decode
    import click_bcd_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_DASH;
        unique case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        seg = ACTIVE_LOW ? ~pat : pat;
    end

endmodule

// File: rtl/click_bcd_display.sv
// BCD up/down counter driven by click pulses, shown on a time-multiplexed 7-segment display.
module click_bcd_display
    import click_bcd_display_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    click_bcd_display_if.slave   bus
);

    localparam int unsigned CW    = bcd_width(DIGITS);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam logic [7:0]        SEG_IDLE = SEG_OFF ^ {8{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{ACTIVE_LOW}};

    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] sel_q;

    logic              carry;
    logic [3:0]        dig;
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] cur_sel;
    logic [6:0]        cur_pat;

    // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        dig     = '0;
        if (bus.clr_i) begin
            count_d = '0;
        end else if (bus.inc_i ^ bus.dec_i) begin
            carry = 1'b1;
            for (int i = 0; i < int'(DIGITS); i++) begin
                dig = count_q[4*i +: 4];
                if (carry) begin
                    if (bus.inc_i) begin
                        carry = (dig == 4'd9);
                        dig   = carry ? 4'd0 : dig + 4'd1;
                    end else begin
                        carry = (dig == 4'd0);
                        dig   = carry ? 4'd9 : dig - 4'd1;
                    end
                end
                count_d[4*i +: 4] = dig;
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_sel   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit  = count_q[4*i +: 4];
                cur_sel[i] = 1'b1;
            end
        end
    end

    seg7_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_seg7_decode (
        .bcd (cur_digit),
        .seg (cur_pat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_IDLE;
            sel_q   <= SEL_IDLE;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            // dp is never lit, so its pin sits at the inactive level
            seg_q   <= {ACTIVE_LOW, cur_pat};
            sel_q   <= cur_sel ^ SEL_IDLE;
        end
    end

    assign bus.count_o   = count_q;
    assign bus.wrap_o    = wrap_q;
    assign bus.seg_o     = seg_q;
    assign bus.dig_sel_o = sel_q;

endmodule

// File: tb/tb_click_bcd_display.sv
// Scoreboard bench: a decimal-arithmetic model predicts every cycle of two configurations.
module tb_click_bcd_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    click_bcd_display_if #(.DIGITS(4)) bus_a ();
    click_bcd_display_if #(.DIGITS(1)) bus_b ();

    click_bcd_display #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    click_bcd_display #(
        .DIGITS     (1),
        .SCAN_DIV   (3),
        .ACTIVE_LOW (1'b0)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        int n;
        int ticks;
        bit wrap;
        bit blank;
        int didx;
        int ddig;
    } model_t;

    typedef struct {
        logic [15:0] count;
        logic        wrap;
        logic [7:0]  seg;
        logic [7:0]  sel;
    } exp_t;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   armed_a = 1'b0;
    bit   armed_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int n, input int d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
        return r;
    endfunction

    // Counter as a plain integer modulo 10^d; scan position from elapsed cycles.
    function automatic model_t model_step(input model_t m, input int d, input int s,
                                          input bit rst, input bit inc, input bit dec,
                                          input bit clr);
        model_t r;
        int     md;
        r  = m;
        md = pow10(d);
        if (rst) begin
            r.n = 0; r.ticks = 0; r.wrap = 0; r.blank = 1; r.didx = 0; r.ddig = 0;
            return r;
        end
        r.blank = 0;
        r.didx  = (m.ticks / s) % d;
        r.ddig  = (m.n / pow10(r.didx)) % 10;
        r.wrap  = 0;
        if (clr) begin
            r.n = 0;
        end else if (inc && !dec) begin
            r.wrap = (m.n == md - 1);
            r.n    = (m.n + 1) % md;
        end else if (dec && !inc) begin
            r.wrap = (m.n == 0);
            r.n    = (m.n + md - 1) % md;
        end
        r.ticks = m.ticks + 1;
        return r;
    endfunction

    function automatic exp_t make_exp(input model_t m, input int d, input bit al);
        exp_t        e;
        logic [31:0] b;
        logic [7:0]  mask;
        b       = to_bcd(m.n, d);
        mask    = 8'((1 << d) - 1);
        e.count = b[15:0];
        e.wrap  = m.wrap;
        e.seg   = m.blank ? 8'h00 : seg_tab[m.ddig];
        e.sel   = m.blank ? 8'h00 : 8'(1 << m.didx);
        if (al) begin
            e.seg = ~e.seg;
            e.sel = ~e.sel & mask;
        end
        return e;
    endfunction

    initial begin
        model_t m;
        m = '{default: 0};
        forever begin
            @(posedge clk);
            if (rst_a) armed_a = 1'b1;
            if (armed_a) begin
                m = model_step(m, 4, 4, rst_a, bus_a.inc_i, bus_a.dec_i, bus_a.clr_i);
                q_a.push_back(make_exp(m, 4, 1'b1));
            end
        end
    end

    initial begin
        model_t m;
        m = '{default: 0};
        forever begin
            @(posedge clk);
            if (rst_b) armed_b = 1'b1;
            if (armed_b) begin
                m = model_step(m, 1, 3, rst_b, bus_b.inc_i, bus_b.dec_i, bus_b.clr_i);
                q_b.push_back(make_exp(m, 1, 1'b0));
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_queue: no expected entry at t=%0t", $time);
                end else begin
                    e = q_a.pop_front();
                    chk("a_count", 32'(bus_a.count_o), 32'(e.count));
                    chk("a_wrap", 32'(bus_a.wrap_o), 32'(e.wrap));
                    chk("a_seg", 32'(bus_a.seg_o), 32'(e.seg));
                    chk("a_sel", 32'(bus_a.dig_sel_o), 32'(e.sel[3:0]));
                end
            end
            if (armed_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_queue: no expected entry at t=%0t", $time);
                end else begin
                    e = q_b.pop_front();
                    chk("b_count", 32'(bus_b.count_o), 32'(e.count[3:0]));
                    chk("b_wrap", 32'(bus_b.wrap_o), 32'(e.wrap));
                    chk("b_seg", 32'(bus_b.seg_o), 32'(e.seg));
                    chk("b_sel", 32'(bus_b.dig_sel_o), 32'(e.sel[0]));
                end
            end
        end
    end

    task automatic drive_a(input bit inc, input bit dec, input bit clr, input bit rst);
        bus_a.inc_i = inc;
        bus_a.dec_i = dec;
        bus_a.clr_i = clr;
        rst_a       = rst;
        @(negedge clk);
    endtask

    task automatic drive_b(input bit inc, input bit dec, input bit clr, input bit rst);
        bus_b.inc_i = inc;
        bus_b.dec_i = dec;
        bus_b.clr_i = clr;
        rst_b       = rst;
        @(negedge clk);
    endtask

    task automatic pulse_a(input bit inc, input bit dec, input bit clr);
        drive_a(inc, dec, clr, 1'b0);
    endtask

    initial begin
        bit found;
        int r;
        bus_a.inc_i = 0; bus_a.dec_i = 0; bus_a.clr_i = 0; rst_a = 1;
        bus_b.inc_i = 0; bus_b.dec_i = 0; bus_b.clr_i = 0; rst_b = 1;
        @(negedge clk);
        @(negedge clk);
        chk("a_reset_count", 32'(bus_a.count_o), 32'h0000);
        chk("a_reset_sel", 32'(bus_a.dig_sel_o), 32'hF);
        chk("a_reset_seg", 32'(bus_a.seg_o), 32'hFF);
        chk("b_reset_sel", 32'(bus_b.dig_sel_o), 32'h0);
        chk("b_reset_seg", 32'(bus_b.seg_o), 32'h00);

        rst_b = 0;
        drive_a(0, 0, 0, 0);
        chk("a_first_sel", 32'(bus_a.dig_sel_o), 32'hE);
        chk("a_first_seg", 32'(bus_a.seg_o), 32'hC0);
        chk("b_first_sel", 32'(bus_b.dig_sel_o), 32'h1);
        repeat (20) pulse_a(0, 0, 0);

        repeat (12) begin
            pulse_a(1, 0, 0);
            pulse_a(0, 0, 0);
        end
        chk("a_after_12_inc", 32'(bus_a.count_o), 32'h0012);
        pulse_a(0, 1, 0);
        chk("a_after_dec", 32'(bus_a.count_o), 32'h0011);
        found = 0;
        for (int k = 0; k < 16 && !found; k++) begin
            if (bus_a.dig_sel_o == 4'hD) found = 1;
            else pulse_a(0, 0, 0);
        end
        chk("a_dig1_seen", 32'(found), 32'd1);
        if (found) chk("a_dig1_seg", 32'(bus_a.seg_o), 32'hF9);

        pulse_a(0, 0, 1);
        chk("a_clr", 32'(bus_a.count_o), 32'h0000);
        pulse_a(0, 1, 0);
        chk("a_wrap_down_count", 32'(bus_a.count_o), 32'h9999);
        chk("a_wrap_down_flag", 32'(bus_a.wrap_o), 32'd1);
        pulse_a(0, 0, 0);
        chk("a_wrap_flag_clears", 32'(bus_a.wrap_o), 32'd0);
        pulse_a(1, 0, 0);
        chk("a_wrap_up_count", 32'(bus_a.count_o), 32'h0000);
        chk("a_wrap_up_flag", 32'(bus_a.wrap_o), 32'd1);

        repeat (5) pulse_a(1, 0, 0);
        pulse_a(1, 1, 0);
        chk("a_inc_dec_hold", 32'(bus_a.count_o), 32'h0005);
        pulse_a(1, 1, 1);
        chk("a_all_clr", 32'(bus_a.count_o), 32'h0000);
        chk("a_all_no_wrap", 32'(bus_a.wrap_o), 32'd0);

        for (int k = 1; k <= 3; k++) begin
            pulse_a(1, 0, 0);
            chk("a_held_inc", 32'(bus_a.count_o), 32'(k));
        end
        drive_a(1, 0, 0, 1);
        chk("a_midrst_count", 32'(bus_a.count_o), 32'h0000);
        chk("a_midrst_sel", 32'(bus_a.dig_sel_o), 32'hF);
        pulse_a(0, 0, 0);
        chk("a_restart_sel", 32'(bus_a.dig_sel_o), 32'hE);

        // Start near the top so random walks cross the wrap point.
        repeat (3) pulse_a(0, 1, 0);
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            drive_a(r < 40, (r >= 35) && (r < 75), r >= 97, $urandom_range(0, 199) == 0);
        end
        pulse_a(0, 0, 0);

        repeat (9) begin
            drive_b(1, 0, 0, 0);
            drive_b(0, 0, 0, 0);
        end
        chk("b_count_9", 32'(bus_b.count_o), 32'h9);
        drive_b(0, 0, 0, 0);
        chk("b_seg_9", 32'(bus_b.seg_o), 32'h6F);
        drive_b(1, 0, 0, 0);
        chk("b_wrap_count", 32'(bus_b.count_o), 32'h0);
        chk("b_wrap_flag", 32'(bus_b.wrap_o), 32'd1);
        drive_b(0, 0, 0, 0);
        chk("b_seg_0", 32'(bus_b.seg_o), 32'h3F);
        chk("b_sel_on", 32'(bus_b.dig_sel_o), 32'h1);
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            drive_b(r < 45, (r >= 40) && (r < 80), r >= 97, $urandom_range(0, 149) == 0);
        end
        drive_b(0, 0, 0, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/click_bcd_display.md
Name: click_bcd_display

Overview:
- Downstream consumer of the key click-pulse stage.
- Takes single-cycle increment, decrement and clear click pulses and maintains a DIGITS-wide BCD up/down counter.
- Drives a time-multiplexed, common-select 7-segment display with the counter value.
- Sits between the debounced key front end and the board display pins.

Parameters:
- DIGITS, 4, number of BCD digits and display positions; legal range 1..8.
- SCAN_DIV, 50000, clk_i cycles each digit is held before the scan advances; minimum 2.
- ACTIVE_LOW, 1, when 1 seg_o and dig_sel_o are active-low; when 0 they are active-high.

Ports:
- clk_i, input, 1, single system clock; all state changes on its rising edge.
- rst_i, input, 1, synchronous, active-high reset.
- inc_i, input, 1, one-cycle click pulse: count +1.
- dec_i, input, 1, one-cycle click pulse: count -1.
- clr_i, input, 1, one-cycle click pulse: count to 0.
- count_o, output, 4*DIGITS, registered BCD count; digit 0 in bits [3:0].
- wrap_o, output, 1, one-cycle pulse when the count wraps in either direction.
- seg_o, output, 8, segments: bit0=a … bit6=g, bit7=dp.
- dig_sel_o, output, DIGITS, one-hot digit enable; bit 0 is the least significant digit.

Behaviour:
- Reset (rst_i high at a clock edge), all values below are logical before ACTIVE_LOW polarity is applied:
  - count_o=0, wrap_o=0.
  - Prescaler=0, scan index=0.
  - seg_o all segments off, dig_sel_o all digits off.
- Counter update, registered, visible the cycle after the pulse is sampled:
  - Priority: clr_i > (inc_i xor dec_i).
  - inc_i and dec_i high together with clr_i low: no change.
  - Increment: ripple BCD; a digit at 9 becomes 0 and carries into the next digit.
  - Decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - Wrap: all-9s +1 gives all-0s; all-0s -1 gives all-9s. In both cases wrap_o=1 for exactly that update cycle, otherwise 0.
  - clr_i never asserts wrap_o.
- Pulses are treated as levels per cycle:
  - A pulse held high for N cycles produces N steps; this block adds no edge detection.
  - Back-to-back pulses on consecutive cycles each count.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On the cycle it is at SCAN_DIV-1, it returns to 0 and the scan index advances, wrapping DIGITS-1 to 0.
  - The prescaler and scan index free-run; counter events do not disturb them.
- Display outputs, registered one cycle behind the scan index and count:
  - dig_sel_o asserts only the bit for the index.
  - seg_o shows that digit of count_o.
  - dp is always off.
  - First non-blank output appears the cycle after reset deasserts, showing digit 0.
- Segment codes, active-high form, bits g..a: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Any non-BCD value (unreachable) maps to 0x40, dash only.
  - When ACTIVE_LOW=1, both seg_o and dig_sel_o are bitwise inverted.
- Reset mid-operation: takes effect at the next edge irrespective of pending pulses or scan position; pulses coincident with reset are discarded.
- DIGITS=1: scan index fixed at 0, dig_sel_o permanently asserted after the first post-reset cycle.

Decomposition:
- Shared package holds:
  - The seg code constants for 0–9 and the dash code.
  - SEG_OFF.
  - A function for the BCD width (4*DIGITS).
- Sub-module seg7_decode: combinational 4-bit BCD to 7-bit pattern, with an ACTIVE_LOW parameter. It is instantiated once on the muxed digit.
- Counter, prescaler and scan logic stay in the top module.

Test Plan:
- Reset, DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1, then idle:
  - count_o=16'h0000.
  - dig_sel_o walks 4'b1110→1101→1011→0111 every 4 cycles.
  - seg_o=8'hC0 for every digit.
- 12 single inc_i pulses, then one dec_i:
  - count_o=16'h0012 after the increments, then 16'h0011.
  - The digit-1 slot shows seg_o=8'hF9.
- Wrap, starting from count 0000:
  - dec_i gives count_o=16'h9999 and wrap_o high for 1 cycle.
  - inc_i gives 16'h0000 and wrap_o pulses again.
- Simultaneous inputs, count 0005:
  - inc_i and dec_i together: count stays 0005.
  - inc_i, dec_i and clr_i together: count becomes 0000, wrap_o=0.
- inc_i held high 3 cycles, then rst_i asserted for 1 cycle while inc_i is high:
  - count_o shows 1, 2, 3 on successive cycles, then 0000.
  - The display is blank for one cycle, then restarts at digit 0.
- DIGITS=1, ACTIVE_LOW=0, count 9 then inc_i:
  - count_o=4'h0, wrap_o pulses.
  - dig_sel_o stays 1'b1; seg_o goes 8'h6F→8'h3F.
